// File: rtl/load_store_unit.sv
// load_store_unit: memory-access unit between the multicycle core datapath and
// a request/acknowledge memory bus. Builds byte enables and lane-replicated store
// data, and extracts and sign/zero-extends load data for the RV32I load and store
// widths (byte, half, word). Rejects illegal or misaligned requests without
// touching the bus.
//
// Optional feature: macro LSU_TIMEOUT_EN. When it is defined, an access that
// waits TIMEOUT_CYCLES cycles without mem_ack is aborted and reports bus_error.
// When it is undefined, the unit waits for mem_ack indefinitely and bus_error
// is tied to 0.
//
// Ports:
//   clk, reset         rising-edge clock; asynchronous active-high reset
//   req_read/req_write load/store request, sampled only in IDLE
//   req_funct3         [1:0] size (00 byte, 01 half, 10 word); [2] unsigned load
//   req_address        byte address
//   req_write_data     right-justified store data
//   busy               high whenever the unit is not IDLE
//   done               one-cycle completion pulse
//   load_data          extended load result (held until the next completion)
//   misaligned         qualifies done: the request was rejected
//   bus_error          qualifies done: the access timed out
//   mem_read/mem_write memory strobes, held until mem_ack
//   mem_address        word-aligned address
//   mem_byte_enable    byte lane strobes
//   mem_write_data     lane-replicated store data
//   mem_read_data      memory read word
//   mem_ack            access complete, sampled at the rising edge

module load_store_unit #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [31:0]           req_write_data,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           load_data,
  output logic                  misaligned,
  output logic                  bus_error,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [3:0]            mem_byte_enable,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data,
  input  logic                  mem_ack
);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  state_e     state;
  logic [1:0] off_q;     // byte offset of the captured address
  logic [2:0] funct3_q;  // captured funct3 (size and unsigned flag)

  // Request decode, evaluated on the raw request inputs while IDLE.
  logic [1:0]  req_size;
  logic [1:0]  req_off;
  logic        req_valid;
  logic        req_illegal;
  logic        req_unaligned;
  logic        req_reject;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  always_comb begin
    req_size      = req_funct3[1:0];
    req_off       = req_address[1:0];
    req_valid     = req_read | req_write;
    req_illegal   = (req_read & req_write) | (req_size == 2'b11) | (req_funct3[2] & req_write);
    req_unaligned = ((req_size == 2'b01) & req_off[0]) |
                    ((req_size == 2'b10) & (req_off != 2'b00));
    req_reject    = req_illegal | req_unaligned;

    be_next    = 4'b0000;
    wdata_next = 32'h0;
    unique case (req_size)
      2'b00: begin
        be_next    = 4'b0001 << req_off;
        wdata_next = {4{req_write_data[7:0]}};
      end
      2'b01: begin
        be_next    = 4'b0011 << req_off;
        wdata_next = {2{req_write_data[15:0]}};
      end
      2'b10: begin
        be_next    = 4'b1111;
        wdata_next = req_write_data;
      end
      default: begin
        be_next    = 4'b0000;
        wdata_next = 32'h0;
      end
    endcase
  end

  // Load extraction from the returned word, using the captured offset and funct3.
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;

  always_comb begin
    unique case (off_q)
      2'b00:   load_byte = mem_read_data[7:0];
      2'b01:   load_byte = mem_read_data[15:8];
      2'b10:   load_byte = mem_read_data[23:16];
      default: load_byte = mem_read_data[31:24];
    endcase
    load_half = off_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];

    load_ext = 32'h0;
    unique case (funct3_q[1:0])
      2'b00:   load_ext = {{24{~funct3_q[2] & load_byte[7]}}, load_byte};
      2'b01:   load_ext = {{16{~funct3_q[2] & load_half[15]}}, load_half};
      2'b10:   load_ext = mem_read_data;
      default: load_ext = 32'h0;
    endcase
  end

  // Timeout detection.
  logic timeout_hit;

`ifdef LSU_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  always_comb begin
    timeout_hit = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
  end
`else
  logic unused_timeout_cycles;

  assign unused_timeout_cycles = ^(16'(TIMEOUT_CYCLES));

  always_comb begin
    timeout_hit = 1'b0;
  end
`endif

  assign busy = (state != StIdle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= StIdle;
      off_q           <= 2'b00;
      funct3_q        <= 3'b000;
      done            <= 1'b0;
      load_data       <= 32'h0;
      misaligned      <= 1'b0;
      bus_error       <= 1'b0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_byte_enable <= 4'b0000;
      mem_write_data  <= 32'h0;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt         <= 16'h0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          done <= 1'b0;
          if (req_valid) begin
            off_q    <= req_off;
            funct3_q <= req_funct3;
            if (req_reject) begin
              // Rejected requests complete next cycle without touching the bus.
              state      <= StDone;
              done       <= 1'b1;
              misaligned <= 1'b1;
              bus_error  <= 1'b0;
              load_data  <= 32'h0;
            end else begin
              state           <= StAccess;
              mem_read        <= req_read;
              mem_write       <= req_write;
              mem_address     <= {req_address[ADDR_WIDTH-1:2], 2'b00};
              mem_byte_enable <= be_next;
              mem_write_data  <= wdata_next;
`ifdef LSU_TIMEOUT_EN
              tmo_cnt         <= 16'h0;
`endif
            end
          end
        end

        StAccess: begin
          if (mem_ack) begin
            // Strobes drop on the acknowledging edge so no second access is issued.
            state      <= StDone;
            done       <= 1'b1;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
            load_data  <= mem_write ? 32'h0 : load_ext;
          end else if (timeout_hit) begin
            state      <= StDone;
            done       <= 1'b1;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            misaligned <= 1'b0;
            bus_error  <= 1'b1;
            load_data  <= 32'h0;
          end else begin
`ifdef LSU_TIMEOUT_EN
            tmo_cnt <= tmo_cnt + 16'h1;
`endif
          end
        end

        StDone: begin
          done  <= 1'b0;
          state <= StIdle;
        end

        default: begin
          done  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
